// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared widths, memory port encodings and copy engine state codes
package dmem_pkg;

    localparam int data_WIDTH = 32;
    localparam int ADDR_WIDTH = 10;

    localparam logic MEM_WRITE = 1'b0;
    localparam logic MEM_READ  = 1'b1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_CAP  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

endpackage

// File: rtl/dmem_copy_engine_if.sv
// rtl/dmem_copy_engine_if.sv - datamemory port bundle between the copy engine and the memory
interface dmem_copy_engine_if #(
    parameter int data_WIDTH = dmem_pkg::data_WIDTH,
    parameter int ADDR_WIDTH = dmem_pkg::ADDR_WIDTH
);

    logic [ADDR_WIDTH-1:0] mem_ADDR;
    logic                  mem_RW_RD;
    logic [data_WIDTH-1:0] mem_din;
    logic [data_WIDTH-1:0] mem_dout;

    modport master (
        output mem_ADDR,
        output mem_RW_RD,
        output mem_din,
        input  mem_dout
    );

    modport slave (
        input  mem_ADDR,
        input  mem_RW_RD,
        input  mem_din,
        output mem_dout
    );

endinterface

// File: rtl/dmem_copy_engine.sv
// rtl/dmem_copy_engine.sv - block copy / fill engine acting as a second datamemory master
module dmem_copy_engine
    import dmem_pkg::*;
#(
    parameter int data_WIDTH = dmem_pkg::data_WIDTH,
    parameter int ADDR_WIDTH = dmem_pkg::ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [data_WIDTH-1:0] pattern,
    output logic                  busy,
    output logic                  done,
    dmem_copy_engine_if.master    mem
);

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic                  mode_q;
    logic [data_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH:0]   i;
    logic [ADDR_WIDTH:0]   i_nxt;
    logic                  last;

    assign i_nxt = i + 1'b1;
    assign last  = (i_nxt == len_q);

    // data_q doubles as the write-data register: it holds the fill pattern in
    // fill mode and the captured read word in copy mode.
    assign mem.mem_din = data_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem.mem_ADDR  <= '0;
            mem.mem_RW_RD <= MEM_READ;
            data_q        <= '0;
            i             <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            len_q         <= '0;
            mode_q        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done          <= 1'b0;
                    mem.mem_RW_RD <= MEM_READ;
                    if (start) begin
                        src_q  <= src_addr;
                        dst_q  <= dst_addr;
                        len_q  <= len;
                        mode_q <= mode;
                        i      <= '0;
                        if (len == '0) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else if (mode) begin
                            state         <= ST_WR;
                            busy          <= 1'b1;
                            data_q        <= pattern;
                            mem.mem_ADDR  <= dst_addr;
                            mem.mem_RW_RD <= MEM_WRITE;
                        end else begin
                            state        <= ST_RD;
                            busy         <= 1'b1;
                            mem.mem_ADDR <= src_addr;
                        end
                    end
                end
                ST_RD: begin
                    state <= ST_CAP;
                end
                ST_CAP: begin
                    state         <= ST_WR;
                    data_q        <= mem.mem_dout;
                    mem.mem_ADDR  <= dst_q + i[ADDR_WIDTH-1:0];
                    mem.mem_RW_RD <= MEM_WRITE;
                end
                ST_WR: begin
                    i <= i_nxt;
                    if (last) begin
                        state         <= ST_FIN;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        mem.mem_RW_RD <= MEM_READ;
                    end else if (mode_q) begin
                        mem.mem_ADDR <= dst_q + i_nxt[ADDR_WIDTH-1:0];
                    end else begin
                        state         <= ST_RD;
                        mem.mem_ADDR  <= src_q + i_nxt[ADDR_WIDTH-1:0];
                        mem.mem_RW_RD <= MEM_READ;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb/tb_dmem_copy_engine.sv - scoreboard bench for dmem_copy_engine against a behavioural datamemory
module tb_dmem_copy_engine;
    import dmem_pkg::*;

    localparam int AW = ADDR_WIDTH;
    localparam int DW = data_WIDTH;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] pattern = '0;
    logic          busy;
    logic          done;

    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [DW-1:0] poke_data = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    wr_t           wr_q[$];
    int            done_q[$];
    int            kc;
    int            bcnt;

    dmem_copy_engine_if bus ();

    dmem_copy_engine dut (
        .CLK      (clk),
        .RST      (rst),
        .start    (start),
        .mode     (mode),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .pattern  (pattern),
        .busy     (busy),
        .done     (done),
        .mem      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // datamemory model: write on the edge, registered read one cycle later
    always @(posedge clk) begin
        if (poke_en)
            mem[poke_addr] <= poke_data;
        else if (bus.mem_RW_RD == MEM_WRITE)
            mem[bus.mem_ADDR] <= bus.mem_din;
        bus.mem_dout <= mem[bus.mem_ADDR];
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        wr_q.push_back(e);
    endtask

    // done_off < 0: no completion expected for this command
    task automatic issue(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW:0] n, input logic [DW-1:0] p, input int done_off);
        @(negedge clk);
        mode = m; src_addr = s; dst_addr = d; len = n; pattern = p;
        start = 1'b1;
        kc = cyc;
        if (done_off >= 0) done_q.push_back(kc + done_off);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit seen = 0;
        bcnt = 0;
        for (int n = 0; n < bound; n++) begin
            if (busy) bcnt++;
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout got=none exp=done within %0d cycles", bound);
        end
        @(negedge clk);
    endtask

    // monitor: every write cycle and every done pulse is matched against the queues
    initial begin
        wr_t e;
        int  ed;
        forever begin
            @(negedge clk);
            if (!rst && bus.mem_RW_RD === MEM_WRITE) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected got=addr %0d data %0h exp=no write", bus.mem_ADDR, bus.mem_din);
                end else begin
                    e = wr_q.pop_front();
                    if (bus.mem_ADDR !== e.a || bus.mem_din !== e.d) begin
                        errors++;
                        $display("FAIL wr_txn got=addr %0d data %0h exp=addr %0d data %0h",
                                 bus.mem_ADDR, bus.mem_din, e.a, e.d);
                    end
                end
            end
            if (!rst && done === 1'b1) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected got=done at cycle %0d exp=no done", cyc);
                end else begin
                    ed = done_q.pop_front();
                    if (cyc != ed) begin
                        errors++;
                        $display("FAIL done_cycle got=%0d exp=%0d", cyc, ed);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", bus.mem_ADDR, 0);
        check("rst_rw", bus.mem_RW_RD, 1);
        check("rst_din", bus.mem_din, 0);
        rst = 1'b0;

        // straight copy of five words
        for (int j = 0; j < 5; j++) poke(AW'(j), DW'(10 + j));
        for (int j = 0; j < 5; j++) push_wr(AW'(100 + j), DW'(10 + j));
        issue(1'b0, 10'd0, 10'd100, 11'd5, '0, 16);
        wait_done(100);
        check("copy_busy_cycles", bcnt, 15);
        for (int j = 0; j < 5; j++) check("copy_mem", mem[100 + j], DW'(10 + j));

        // fill three words, neighbour untouched
        poke(10'd203, 32'd123);
        for (int j = 0; j < 3; j++) push_wr(AW'(200 + j), 32'hDEADBEEF);
        issue(1'b1, 10'd0, 10'd200, 11'd3, 32'hDEADBEEF, 4);
        wait_done(100);
        check("fill_busy_cycles", bcnt, 3);
        check("fill_mem201", mem[201], 32'hDEADBEEF);
        check("fill_mem203", mem[203], 32'd123);

        // source range wraps past the top of memory
        poke(10'd1022, 32'hA0);
        poke(10'd1023, 32'hB0);
        poke(10'd0, 32'hC0);
        poke(10'd1, 32'hD0);
        push_wr(10'd500, 32'hA0);
        push_wr(10'd501, 32'hB0);
        push_wr(10'd502, 32'hC0);
        push_wr(10'd503, 32'hD0);
        issue(1'b0, 10'd1022, 10'd500, 11'd4, '0, 13);
        wait_done(100);
        check("wrap_mem500", mem[500], 32'hA0);
        check("wrap_mem503", mem[503], 32'hD0);

        // zero length: done next cycle, no memory write
        issue(1'b0, 10'd5, 10'd5, 11'd0, '0, 1);
        wait_done(10);
        check("len0_busy_cycles", bcnt, 0);

        // start while busy is ignored
        poke(10'd600, 32'd5);
        for (int j = 0; j < 3; j++) push_wr(AW'(300 + j), 32'd77);
        issue(1'b1, 10'd0, 10'd300, 11'd3, 32'd77, 4);
        mode = 1'b0; src_addr = 10'd0; dst_addr = 10'd600; len = 11'd5; pattern = 32'd99;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100);
        check("busy_start_mem302", mem[302], 32'd77);
        check("busy_start_mem600", mem[600], 32'd5);

        // reset during the third word of a ten-word copy
        for (int j = 0; j < 10; j++) poke(AW'(j), DW'(50 + j));
        poke(10'd702, 32'h5A5A);
        push_wr(10'd700, 32'd50);
        push_wr(10'd701, 32'd51);
        issue(1'b0, 10'd0, 10'd700, 11'd10, '0, -1);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_rw", bus.mem_RW_RD, 1);
        check("abort_done", done, 0);
        check("abort_addr", bus.mem_ADDR, 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_mem701", mem[701], 32'd51);
        check("abort_mem702", mem[702], 32'h5A5A);

        // overlapping ranges propagate the first word upward
        for (int j = 0; j < 4; j++) poke(AW'(j), DW'(1 + j));
        for (int j = 1; j < 4; j++) push_wr(AW'(j), 32'd1);
        issue(1'b0, 10'd0, 10'd1, 11'd3, '0, 10);
        wait_done(100);
        for (int j = 0; j < 4; j++) check("overlap_mem", mem[j], 32'd1);

        repeat (5) @(negedge clk);
        check("wr_q_left", wr_q.size(), 0);
        check("done_q_left", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
